// File: rtl/operand_fetch_stage.sv
// Decode/operand-fetch stage: drives the register bank read ports, registers operands for execute
// and stalls RAW hazards via per-register pending-write counters. Optional macro: WB_BYPASS_EN.
module operand_fetch_stage #(
   parameter int PEND_W = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   output logic [3:0]  read_reg1,
   output logic [3:0]  read_reg2,
   input  logic [31:0] read_data1,
   input  logic [31:0] read_data2,
   input  logic        wb_reg_write,
   input  logic [3:0]  wb_write_reg,
   input  logic [31:0] wb_write_data,
   output logic        ex_valid,
   input  logic        ex_ready,
   output logic [5:0]  ex_opcode,
   output logic [3:0]  ex_rd,
   output logic [31:0] ex_op_a,
   output logic [31:0] ex_op_b,
   output logic [31:0] ex_imm
);
   localparam int NREG = 16;
   localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

   logic [5:0]        w_opcode;
   logic [3:0]        w_rd;
   logic [3:0]        w_rs1;
   logic [3:0]        w_rs2;
   logic [13:0]       w_imm;
   logic              w_writes_rd;
   logic              w_accept;
   logic              w_hazard;
   logic              w_haz1;
   logic              w_haz2;
   logic              w_haz_rd;
   logic [31:0]       w_data1;
   logic [31:0]       w_data2;
   logic [PEND_W-1:0] w_pend_rs1;
   logic [PEND_W-1:0] w_pend_rs2;
   logic [PEND_W-1:0] w_pend_rd;
   logic [NREG-1:0]   w_inc;
   logic [NREG-1:0]   w_dec;

   logic [PEND_W-1:0] r_pend [NREG];
   logic              r_ex_valid;
   logic [5:0]        r_ex_opcode;
   logic [3:0]        r_ex_rd;
   logic [31:0]       r_ex_op_a;
   logic [31:0]       r_ex_op_b;
   logic [31:0]       r_ex_imm;

   assign w_opcode    = in_instr[31:26];
   assign w_rd        = in_instr[25:22];
   assign w_rs1       = in_instr[21:18];
   assign w_rs2       = in_instr[17:14];
   assign w_imm       = in_instr[13:0];
   assign read_reg1   = w_rs1;
   assign read_reg2   = w_rs2;
   assign w_writes_rd = !w_opcode[5] && (w_rd != 4'd0);

   assign w_pend_rs1 = r_pend[w_rs1];
   assign w_pend_rs2 = r_pend[w_rs2];
   assign w_pend_rd  = r_pend[w_rd];

`ifdef WB_BYPASS_EN
   logic w_byp1;
   logic w_byp2;
   assign w_byp1  = wb_reg_write && (wb_write_reg == w_rs1) && (w_rs1 != 4'd0);
   assign w_byp2  = wb_reg_write && (wb_write_reg == w_rs2) && (w_rs2 != 4'd0);
   // The retiring write is the last one outstanding, so its data can be used right now.
   assign w_haz1  = (w_rs1 != 4'd0) && (w_pend_rs1 != '0) && !(w_byp1 && (w_pend_rs1 == PEND_W'(1)));
   assign w_haz2  = (w_rs2 != 4'd0) && (w_pend_rs2 != '0) && !(w_byp2 && (w_pend_rs2 == PEND_W'(1)));
   assign w_data1 = w_byp1 ? wb_write_data : read_data1;
   assign w_data2 = w_byp2 ? wb_write_data : read_data2;
`else
   logic w_unused_wb;
   assign w_unused_wb = ^wb_write_data;
   assign w_haz1  = (w_rs1 != 4'd0) && (w_pend_rs1 != '0);
   assign w_haz2  = (w_rs2 != 4'd0) && (w_pend_rs2 != '0);
   assign w_data1 = read_data1;
   assign w_data2 = read_data2;
`endif

   assign w_haz_rd = w_writes_rd && (w_pend_rd == PEND_MAX);
   assign w_hazard = w_haz1 || w_haz2 || w_haz_rd;
   assign in_ready = (!r_ex_valid || ex_ready) && !w_hazard;
   assign w_accept = in_valid && in_ready;

   genvar gi;
   generate
      for (gi = 0; gi < NREG; gi++) begin : g_sb
         if (gi == 0) begin : g_r0
            assign w_inc[gi] = 1'b0;
            assign w_dec[gi] = 1'b0;
         end else begin : g_rn
            assign w_inc[gi] = w_accept && w_writes_rd && (w_rd == 4'(gi));
            assign w_dec[gi] = wb_reg_write && (wb_write_reg == 4'(gi));
         end
      end
   endgenerate

   // Simultaneous issue and retire of the same register leaves its count unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) r_pend[i] <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (w_inc[i] && !w_dec[i])
               r_pend[i] <= r_pend[i] + PEND_W'(1);
            else if (w_dec[i] && !w_inc[i] && (r_pend[i] != '0))
               r_pend[i] <= r_pend[i] - PEND_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex_valid  <= 1'b0;
         r_ex_opcode <= '0;
         r_ex_rd     <= '0;
         r_ex_op_a   <= '0;
         r_ex_op_b   <= '0;
         r_ex_imm    <= '0;
      end else if (w_accept) begin
         r_ex_valid  <= 1'b1;
         r_ex_opcode <= w_opcode;
         r_ex_rd     <= w_rd;
         r_ex_op_a   <= (w_rs1 == 4'd0) ? 32'd0 : w_data1;
         r_ex_op_b   <= (w_rs2 == 4'd0) ? 32'd0 : w_data2;
         r_ex_imm    <= {{18{w_imm[13]}}, w_imm};
      end else if (ex_ready) begin
         r_ex_valid  <= 1'b0;
      end
   end

   assign ex_valid  = r_ex_valid;
   assign ex_opcode = r_ex_opcode;
   assign ex_rd     = r_ex_rd;
   assign ex_op_a   = r_ex_op_a;
   assign ex_op_b   = r_ex_op_b;
   assign ex_imm    = r_ex_imm;
endmodule
